// File: rtl/vga_rx_decoder.sv
// VGA link receiver: samples sync/RGB on pixel strobes, recovers coordinates, checks timing, emits pixel stream.
// Optional per-frame RGB checksum is built when VGA_RX_SUM_EN is defined.
module vga_rx_decoder #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pix_en,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic [11:0] i_rgb,
  output logic        o_pix_valid,
  output logic [9:0]  o_pix_x,
  output logic [9:0]  o_pix_y,
  output logic [11:0] o_pix_rgb,
  output logic        o_sof,
  output logic        o_eol,
  output logic        o_locked,
  output logic        o_err,
  output logic [10:0] o_h_total,
  output logic [9:0]  o_v_total,
  output logic [15:0] o_frame_sum,
  output logic        o_frame_done
);

  localparam int unsigned HW      = 11;
  localparam int unsigned VW      = 10;
  localparam int unsigned XW      = 10;
  localparam int unsigned YW      = 10;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_START = H_SYNC + H_BP;
  localparam int unsigned H_END   = H_START + H_ACTIVE;
  localparam int unsigned V_START = V_SYNC + V_BP;
  localparam int unsigned V_END   = V_START + V_ACTIVE;
  localparam logic [HW-1:0] H_MAX = {HW{1'b1}};
  localparam logic [VW-1:0] V_MAX = {VW{1'b1}};

  typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

  state_t        state, state_nxt;
  logic          s_hs, s_vs, s_hs_d, s_vs_d;
  logic [11:0]   s_rgb;
  logic [HW-1:0] h_pos, h_cur, h_len;
  logic [VW-1:0] v_pos, v_cur, v_len;
  logic          vpend;
  logic          hedge, vedge, restart, h_bad, v_bad, h_sat, viol, active, pix_ok;
  logic [XW-1:0] x_cur;
  logic [YW-1:0] y_cur;

  // Position of the sample held in s_*, timing checks and lock FSM next state
  always_comb begin
    hedge     = (s_hs == SYNC_POL) && (s_hs_d != SYNC_POL);
    vedge     = (s_vs == SYNC_POL) && (s_vs_d != SYNC_POL);
    h_len     = h_pos + HW'(1);
    v_len     = v_pos + VW'(1);
    restart   = hedge && (vpend || vedge);
    h_cur     = (h_pos == H_MAX) ? H_MAX : h_len;
    v_cur     = v_pos;
    state_nxt = state;
    if (hedge) begin
      h_cur = '0;
      if (restart)             v_cur = '0;
      else if (v_pos != V_MAX) v_cur = v_len;
    end
    h_bad  = hedge && (h_len != HW'(H_TOTAL));
    v_bad  = restart && (v_len != VW'(V_TOTAL));
    h_sat  = !hedge && (h_pos == H_MAX - HW'(1));
    viol   = h_bad || v_bad || h_sat;
    active = (h_cur >= HW'(H_START)) && (h_cur < HW'(H_END)) &&
             (v_cur >= VW'(V_START)) && (v_cur < VW'(V_END));
    x_cur  = XW'(h_cur - HW'(H_START));
    y_cur  = YW'(v_cur - VW'(V_START));
    case (state)
      SEARCH:  if (vedge) state_nxt = MEASURE;
      MEASURE: if (restart && !h_bad && !v_bad) state_nxt = LOCKED;
      LOCKED:  if (viol) state_nxt = MEASURE;
      default: state_nxt = SEARCH;
    endcase
    pix_ok = (state == LOCKED) && !viol && active;
  end

  // Sync sampling, counters, FSM state and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= SEARCH;
      s_hs        <= ~SYNC_POL;
      s_vs        <= ~SYNC_POL;
      s_hs_d      <= ~SYNC_POL;
      s_vs_d      <= ~SYNC_POL;
      s_rgb       <= '0;
      h_pos       <= '0;
      v_pos       <= '0;
      vpend       <= 1'b0;
      o_pix_valid <= 1'b0;
      o_pix_x     <= '0;
      o_pix_y     <= '0;
      o_pix_rgb   <= '0;
      o_sof       <= 1'b0;
      o_eol       <= 1'b0;
      o_locked    <= 1'b0;
      o_err       <= 1'b0;
      o_h_total   <= '0;
      o_v_total   <= '0;
    end else begin
      o_pix_valid <= 1'b0;
      o_sof       <= 1'b0;
      o_eol       <= 1'b0;
      o_err       <= 1'b0;
      if (i_pix_en) begin
        s_hs   <= i_hsync;
        s_vs   <= i_vsync;
        s_rgb  <= i_rgb;
        s_hs_d <= s_hs;
        s_vs_d <= s_vs;
        state  <= state_nxt;
        h_pos  <= h_cur;
        v_pos  <= v_cur;
        if (hedge)      vpend <= 1'b0;
        else if (vedge) vpend <= 1'b1;
        if (hedge)   o_h_total <= h_len;
        if (restart) o_v_total <= v_len;
        o_locked    <= (state_nxt == LOCKED);
        o_err       <= (state == LOCKED) && viol;
        o_pix_valid <= pix_ok;
        o_sof       <= pix_ok && (x_cur == '0) && (y_cur == '0);
        o_eol       <= pix_ok && (x_cur == XW'(H_ACTIVE - 1));
        if (pix_ok) begin
          o_pix_x   <= x_cur;
          o_pix_y   <= y_cur;
          o_pix_rgb <= s_rgb;
        end
      end
    end
  end

`ifdef VGA_RX_SUM_EN
  logic [15:0] acc, acc_nxt;
  logic        last_pix;

  always_comb begin
    acc_nxt  = (o_sof ? 16'd0 : acc) + 16'(o_pix_rgb);
    last_pix = o_pix_valid && o_eol && (o_pix_y == YW'(V_ACTIVE - 1));
  end

  // Frame checksum accumulates on each emitted pixel; latched after the last one
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      acc          <= '0;
      o_frame_sum  <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      if (o_pix_valid) begin
        acc <= acc_nxt;
        if (last_pix) begin
          o_frame_sum  <= acc_nxt;
          o_frame_done <= 1'b1;
        end
      end
    end
  end
`else
  assign o_frame_sum  = '0;
  assign o_frame_done = 1'b0;
`endif

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Bench for vga_rx_decoder on a reduced 14x7 timing; model tracks positions as distances from sync starts.
module tb_vga_rx_decoder;

  logic        clk = 1'b0;
  logic        rst_n, pix_en, hsync, vsync;
  logic [11:0] rgb;
  logic        o_pix_valid, o_sof, o_eol, o_locked, o_err, o_frame_done;
  logic [9:0]  o_pix_x, o_pix_y, o_v_total;
  logic [11:0] o_pix_rgb;
  logic [10:0] o_h_total;
  logic [15:0] o_frame_sum;

  always #5 clk = ~clk;

  vga_rx_decoder #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en),
    .i_hsync(hsync), .i_vsync(vsync), .i_rgb(rgb),
    .o_pix_valid(o_pix_valid), .o_pix_x(o_pix_x), .o_pix_y(o_pix_y), .o_pix_rgb(o_pix_rgb),
    .o_sof(o_sof), .o_eol(o_eol), .o_locked(o_locked), .o_err(o_err),
    .o_h_total(o_h_total), .o_v_total(o_v_total),
    .o_frame_sum(o_frame_sum), .o_frame_done(o_frame_done)
  );

  typedef struct packed {
    logic        valid;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] rgb;
    logic        sof, eol, locked, err;
    logic [10:0] htot;
    logic [9:0]  vtot;
    logic [15:0] sum;
    logic        done;
  } obs_t;

  int   checks = 0, failures = 0, shown = 0;
  bit   cmp_en = 1'b0;
  obs_t exp_o, nx_o;

  // Model state: the two most recent link samples plus event bookkeeping
  logic        s_hs_m, s_vs_m, p_hs_m, p_vs_m;
  logic [11:0] s_rgb_m;
  int          idx, last_h, n_hedge, restart_mark, mode;
  bit          vpend_m, pend_done;
  logic [15:0] pend_sum = '0;
`ifdef VGA_RX_SUM_EN
  logic [15:0] acc_m = '0;
`endif

  int strobe_no = 0, samp_strobe = 0, sof_strobe = 0;
  int valid_cnt, sof_cnt, eol_cnt, err_cnt, err_htot;

  function automatic int sat(input int d);
    return (d > 2047) ? 2047 : d;
  endfunction

  task automatic model_reset();
    s_hs_m = 1'b1; s_vs_m = 1'b1; p_hs_m = 1'b1; p_vs_m = 1'b1; s_rgb_m = '0;
    idx = -1; last_h = -1; n_hedge = 0; restart_mark = 0; mode = 0;
    vpend_m = 1'b0; pend_done = 1'b0; pend_sum = '0;
`ifdef VGA_RX_SUM_EN
    acc_m = '0;
`endif
    exp_o = '0;
  endtask

  // Evaluate the sample currently held on the link, then accept the new one
  task automatic model_step(input logic hs, input logic vs, input logic [11:0] rgb_in);
    bit he, ve, rs, hbad, vbad, sat_ev, viol, act, valid;
    int prev_h, h, v_prev, v;
    he     = (s_hs_m == 1'b0) && (p_hs_m == 1'b1);
    ve     = (s_vs_m == 1'b0) && (p_vs_m == 1'b1);
    idx    = idx + 1;
    prev_h = sat(idx - 1 - last_h);
    h      = he ? 0 : sat(idx - last_h);
    sat_ev = (h == 2047) && (prev_h != 2047);
    v_prev = n_hedge - restart_mark;
    rs     = he && (vpend_m || ve);
    v      = he ? (rs ? 0 : v_prev + 1) : v_prev;
    hbad   = he && (((prev_h + 1) % 2048) != 14);
    vbad   = rs && (((v_prev + 1) % 1024) != 7);
    viol   = hbad || vbad || sat_ev;
    act    = (h >= 4) && (h < 12) && (v >= 2) && (v < 6);
    valid  = (mode == 2) && !viol && act;
    nx_o = exp_o;
    nx_o.valid = valid; nx_o.sof = 1'b0; nx_o.eol = 1'b0; nx_o.done = 1'b0;
    nx_o.err = (mode == 2) && viol;
    if (valid) begin
      nx_o.x   = 10'(h - 4);
      nx_o.y   = 10'(v - 2);
      nx_o.rgb = s_rgb_m;
      nx_o.sof = (h == 4) && (v == 2);
      nx_o.eol = (h == 11);
`ifdef VGA_RX_SUM_EN
      acc_m = (nx_o.sof ? 16'd0 : acc_m) + 16'(s_rgb_m);
      if (h == 11 && v == 5) begin pend_done = 1'b1; pend_sum = acc_m; end
`endif
    end
    if (he) nx_o.htot = 11'((prev_h + 1) % 2048);
    if (rs) nx_o.vtot = 10'((v_prev + 1) % 1024);
    case (mode)
      0: if (ve) mode = 1;
      1: if (rs && !hbad && !vbad) mode = 2;
      default: if (viol) mode = 1;
    endcase
    nx_o.locked = (mode == 2);
    if (he) begin
      last_h  = idx;
      n_hedge = n_hedge + 1;
      if (rs) restart_mark = n_hedge;
    end
    if (he) vpend_m = 1'b0; else if (ve) vpend_m = 1'b1;
    p_hs_m = s_hs_m; p_vs_m = s_vs_m;
    s_hs_m = hs; s_vs_m = vs; s_rgb_m = rgb_in;
  endtask

  task automatic compare_cycle();
    obs_t act;
    if (!cmp_en) return;
    act = {o_pix_valid, o_pix_x, o_pix_y, o_pix_rgb, o_sof, o_eol, o_locked, o_err,
           o_h_total, o_v_total, o_frame_sum, o_frame_done};
    checks++;
    if (act !== exp_o) begin
      failures++;
      if (shown < 20) begin
        shown++;
        $display("FAIL outputs t=%0t got=%h want=%h", $time, act, exp_o);
      end
    end
    if (o_pix_valid === 1'b1) valid_cnt++;
    if (o_sof === 1'b1) begin sof_cnt++; sof_strobe = strobe_no; end
    if (o_eol === 1'b1) eol_cnt++;
    if (o_err === 1'b1) begin err_cnt++; err_htot = int'(o_h_total); end
  endtask

  task automatic lit(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, actual, expected);
    end
  endtask

  // One clock: drive at posedge+2, compare at negedge, advance expectations after posedge
  task automatic tick(input bit en, input logic hs, input logic vs, input logic [11:0] c);
    pix_en = en; hsync = hs; vsync = vs; rgb = c;
    if (en) begin strobe_no++; model_step(hs, vs, c); end
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
    if (en) exp_o = nx_o;
    else begin
      exp_o.valid = 1'b0; exp_o.sof = 1'b0; exp_o.eol = 1'b0; exp_o.err = 1'b0;
      exp_o.done = pend_done;
      if (pend_done) exp_o.sum = pend_sum;
      pend_done = 1'b0;
    end
    #1;
  endtask

  task automatic send_pixel(input logic hs, input logic vs, input logic [11:0] c);
    tick(1'b1, hs, vs, c);
    repeat (3) tick(1'b0, hs, vs, c);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pix_en = 1'b0;
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  // rgb_mode 0: constant 12'h712, 1: ramp x+8*y; vmode 1 moves the vsync edge mid-line
  task automatic send_frame(input int rgb_mode, input int vmode, input int short_l,
                            input int long_l, input int rst_at);
    valid_cnt = 0; sof_cnt = 0; eol_cnt = 0; err_cnt = 0; err_htot = -1;
    for (int l = 0; l < 7; l++) begin
      int plen;
      plen = (l == short_l) ? 13 : ((l == long_l) ? 2058 : 14);
      for (int p = 0; p < plen; p++) begin
        logic hs, vs;
        logic [11:0] c;
        bit act;
        hs  = (p < 2) ? 1'b0 : 1'b1;
        if (vmode == 0) vs = (l == 0) ? 1'b0 : 1'b1;
        else vs = ((l == 6 && p >= 5) || (l == 0 && p < 5)) ? 1'b0 : 1'b1;
        act = (p >= 4) && (p < 12) && (l >= 2) && (l < 6);
        c   = (rgb_mode == 0) ? 12'h712 : (act ? 12'((p - 4) + 8 * (l - 2)) : 12'h000);
        if (l * 14 + p == rst_at) begin
          do_reset();
          lit("rst_locked", int'(o_locked), 0);
          lit("rst_h_total", int'(o_h_total), 0);
          lit("rst_pix_valid", int'(o_pix_valid), 0);
        end
        if (act && p == 4 && l == 2) samp_strobe = strobe_no + 1;
        send_pixel(hs, vs, c);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1; rgb = '0;
    valid_cnt = 0; sof_cnt = 0; eol_cnt = 0; err_cnt = 0; err_htot = -1;
    @(posedge clk); #2;
    do_reset();
    cmp_en = 1'b1;
    lit("reset_locked", int'(o_locked), 0);
    lit("reset_v_total", int'(o_v_total), 0);

    // Constant colour: lock at the start of the second frame
    send_frame(0, 0, -1, -1, -1);
    lit("f0_locked", int'(o_locked), 0);
    lit("f0_valid", valid_cnt, 0);
    send_frame(0, 0, -1, -1, -1);
    lit("f1_locked", int'(o_locked), 1);
    lit("f1_valid", valid_cnt, 32);
    lit("f1_sof", sof_cnt, 1);
    lit("f1_eol", eol_cnt, 4);
    send_frame(0, 0, -1, -1, -1);
    lit("f2_valid", valid_cnt, 32);
    lit("f2_h_total", int'(o_h_total), 14);
    lit("f2_v_total", int'(o_v_total), 7);
    lit("f2_rgb", int'(o_pix_rgb), 12'h712);

    // Ramp: coordinates track colour, one strobe from sampling to output
    send_frame(1, 0, -1, -1, -1);
    lit("ramp_valid", valid_cnt, 32);
    lit("ramp_sof_latency", sof_strobe - samp_strobe, 1);
    lit("ramp_last_rgb", int'(o_pix_rgb), 31);
`ifdef VGA_RX_SUM_EN
    lit("ramp_frame_sum", int'(o_frame_sum), 496);
`else
    lit("frame_sum_off", int'(o_frame_sum), 0);
`endif

    // One 13-pixel line while locked
    send_frame(1, 0, 3, -1, -1);
    lit("short_err", err_cnt, 1);
    lit("short_h_total", err_htot, 13);
    lit("short_locked", int'(o_locked), 0);
    send_frame(1, 0, -1, -1, -1);
    send_frame(1, 0, -1, -1, -1);
    lit("short_relock", int'(o_locked), 1);
    lit("short_relock_err", err_cnt, 0);

    // Vsync edge in the middle of the last line
    send_frame(1, 1, -1, -1, -1);
    lit("midv_err", err_cnt, 0);
    send_frame(1, 1, -1, -1, -1);
    lit("midv_err2", err_cnt, 0);
    lit("midv_valid", valid_cnt, 32);
    lit("midv_v_total", int'(o_v_total), 7);
    lit("midv_locked", int'(o_locked), 1);

    // Hsync missing long enough for the line counter to saturate
    send_frame(0, 0, -1, 3, -1);
    lit("sat_err", err_cnt, 1);
    lit("sat_locked", int'(o_locked), 0);
    send_frame(0, 0, -1, -1, -1);
    send_frame(0, 0, -1, -1, -1);
    lit("sat_relock", int'(o_locked), 1);

    // Reset in the middle of line 3
    send_frame(1, 0, -1, -1, 3 * 14 + 7);
    lit("rst_partial_locked", int'(o_locked), 0);
    send_frame(1, 0, -1, -1, -1);
    lit("rst_f1_locked", int'(o_locked), 0);
    send_frame(1, 0, -1, -1, -1);
    lit("rst_f2_locked", int'(o_locked), 1);
    lit("rst_f2_valid", valid_cnt, 32);

    repeat (4) tick(1'b0, 1'b1, 1'b1, 12'h000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
